// File: rtl/wdog_rst_pkg.sv
// -----------------------------------------------------------------------------
// wdog_rst_pkg
// Shared definitions for the watchdog reset controller:
//   - wdog_state_t   : controller FSM states (idle, reset pulse, hold-off)
//   - CAUSE_WDOGRES  : rst_cause bit set by a watchdog reset-request rise
//   - CAUSE_ESC      : rst_cause bit set by unacknowledged-interrupt escalation
//   - TMR_W          : width of the pulse/hold-off timer load value
// -----------------------------------------------------------------------------
package wdog_rst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } wdog_state_t;

  localparam int CAUSE_WDOGRES = 0;
  localparam int CAUSE_ESC     = 1;

  // Pulse and hold-off lengths are both limited to 1..255 cycles.
  localparam int TMR_W = 8;

endpackage

// File: rtl/wdog_rst_timer.sv
// -----------------------------------------------------------------------------
// wdog_rst_timer
// Reloadable down-counter used for both the reset pulse and the hold-off
// window. A start strobe loads the count; done is high during the last cycle
// of the loaded interval, so the caller changes state on the edge that ends
// the interval. A load of N therefore yields an interval of exactly N cycles.
//
// Ports:
//   wdg_clk  in   clock
//   wdg_rst  in   synchronous active-high reset
//   load     in   [W-1:0] interval length in cycles (1..2^W-1)
//   start    in   load the counter (takes priority over counting)
//   done     out  high in the final cycle of the interval
// -----------------------------------------------------------------------------
module wdog_rst_timer #(
  parameter int W = 8
) (
  input  logic         wdg_clk,
  input  logic         wdg_rst,
  input  logic [W-1:0] load,
  input  logic         start,
  output logic         done
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge wdg_clk) begin
    if (wdg_rst) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= load;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Counter value 1 marks the last cycle; 0 means the timer is idle.
  assign done = (cnt_reg == W'(1));

endmodule

// File: rtl/wdog_rst_ctrl.sv
// -----------------------------------------------------------------------------
// wdog_rst_ctrl
// Turns watchdog interrupt / reset-request levels into a stretched system
// reset request, a sticky interrupt and a sticky record of why resets were
// issued.
//
// A rising edge of wdogres seen while idle starts a reset pulse of RST_PULSE
// cycles on sys_rst_req, followed by a hold-off window of HOLDOFF cycles in
// which further wdogres rises are ignored. Each accepted trigger sets the
// matching rst_cause bit and bumps the saturating rst_count.
//
// Optional feature, macro WDOG_RST_CTRL_ESCALATE_EN: when defined, wdog_irq
// left unacknowledged for ESC_CYCLES consecutive cycles triggers a reset with
// rst_cause bit1. When undefined, the escalation counter is not built and
// rst_cause bit1 is always 0.
//
// Ports:
//   wdg_clk      in   single clock
//   wdg_rst      in   synchronous active-high power-on reset
//   wdogint      in   watchdog interrupt level
//   wdogres      in   watchdog reset-request level
//   irq_clr      in   one-cycle acknowledge of wdog_irq
//   cause_clr    in   one-cycle clear of rst_cause and rst_count
//   sys_rst_req  out  stretched reset request (registered)
//   wdog_irq     out  sticky interrupt (registered)
//   rst_cause    out  [1:0] bit0 wdogres, bit1 escalation; sticky
//   rst_count    out  [CNT_W-1:0] saturating count of issued reset pulses
//   busy         out  high while not idle (registered)
// -----------------------------------------------------------------------------
module wdog_rst_ctrl
  import wdog_rst_pkg::*;
#(
  parameter int RST_PULSE  = 16,
  parameter int HOLDOFF    = 64,
  parameter int ESC_CYCLES = 1024,
  parameter int CNT_W      = 8
) (
  input  logic             wdg_clk,
  input  logic             wdg_rst,
  input  logic             wdogint,
  input  logic             wdogres,
  input  logic             irq_clr,
  input  logic             cause_clr,
  output logic             sys_rst_req,
  output logic             wdog_irq,
  output logic [1:0]       rst_cause,
  output logic [CNT_W-1:0] rst_count,
  output logic             busy
);

  // Elaboration-time parameter range checks.
  if (RST_PULSE < 1 || RST_PULSE > 255) begin : g_bad_pulse
    $error("wdog_rst_ctrl: RST_PULSE must be 1..255");
  end
  if (HOLDOFF < 1 || HOLDOFF > 255) begin : g_bad_holdoff
    $error("wdog_rst_ctrl: HOLDOFF must be 1..255");
  end
  if (ESC_CYCLES < 1 || ESC_CYCLES > 65535) begin : g_bad_esc
    $error("wdog_rst_ctrl: ESC_CYCLES must be 1..65535");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("wdog_rst_ctrl: CNT_W must be at least 1");
  end

  localparam logic [TMR_W-1:0] PULSE_LOAD   = TMR_W'(RST_PULSE);
  localparam logic [TMR_W-1:0] HOLDOFF_LOAD = TMR_W'(HOLDOFF);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  wdog_state_t      state_reg;
  logic             wdogint_q_reg;
  logic             wdogres_q_reg;
  logic             armed_reg;
  logic             int_rise;
  logic             res_rise;
  logic             esc_hit;
  logic             trigger;
  logic             tmr_start;
  logic             tmr_done;
  logic [TMR_W-1:0] tmr_load;
  logic [1:0]       cause_next;
  logic [CNT_W-1:0] count_next;

  // ---------------------------------------------------------------------------
  // Edge detection. armed_reg stays low for the first edge after reset so a
  // level that was already high across reset is not mistaken for a new rise;
  // a reset request still asserted after power-on reset must not retrigger.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wdg_clk) begin
    if (wdg_rst) begin
      wdogint_q_reg <= 1'b0;
      wdogres_q_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      wdogint_q_reg <= wdogint;
      wdogres_q_reg <= wdogres;
      armed_reg     <= 1'b1;
    end
  end

  assign int_rise = armed_reg & wdogint & ~wdogint_q_reg;
  assign res_rise = armed_reg & wdogres & ~wdogres_q_reg;

  // Only rises seen while idle start a pulse; anything during the pulse or
  // hold-off is dropped rather than queued.
  assign trigger = (state_reg == ST_IDLE) & (res_rise | esc_hit);

  // ---------------------------------------------------------------------------
  // Sticky interrupt: a new rise wins over a coincident acknowledge so an
  // event arriving with the clear is never lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wdg_clk) begin
    if (wdg_rst) begin
      wdog_irq <= 1'b0;
    end else if (int_rise) begin
      wdog_irq <= 1'b1;
    end else if (irq_clr) begin
      wdog_irq <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Escalation: counts consecutive cycles of an unacknowledged interrupt.
  // The counter parks at ESC_CYCLES-1 while the FSM is busy so that an
  // interrupt that stays pending escalates as soon as the FSM is idle again.
  // ---------------------------------------------------------------------------
`ifdef WDOG_RST_CTRL_ESCALATE_EN
  localparam int             ESC_W    = 16;
  localparam logic [ESC_W-1:0] ESC_LAST = ESC_W'(ESC_CYCLES - 1);

  logic [ESC_W-1:0] esc_cnt_reg;

  always_ff @(posedge wdg_clk) begin
    if (wdg_rst || !wdog_irq || trigger) begin
      esc_cnt_reg <= '0;
    end else if (esc_cnt_reg != ESC_LAST) begin
      esc_cnt_reg <= esc_cnt_reg + 1'b1;
    end
  end

  // Fires in the ESC_CYCLES-th consecutive cycle of wdog_irq high.
  assign esc_hit = wdog_irq & (esc_cnt_reg == ESC_LAST);
`else
  assign esc_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Cause / count bookkeeping. A clear is applied first so a trigger in the
  // same cycle leaves exactly its own cause bit and a count of one.
  // ---------------------------------------------------------------------------
  always_comb begin
    cause_next = cause_clr ? 2'b00 : rst_cause;
    count_next = cause_clr ? '0 : rst_count;
    if (trigger) begin
      if (res_rise) cause_next[CAUSE_WDOGRES] = 1'b1;
      if (esc_hit)  cause_next[CAUSE_ESC]     = 1'b1;
      if (count_next != CNT_MAX) count_next = count_next + 1'b1;
    end
  end

  always_ff @(posedge wdg_clk) begin
    if (wdg_rst) begin
      rst_cause <= 2'b00;
      rst_count <= '0;
    end else begin
      rst_cause <= cause_next;
      rst_count <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared interval timer: loaded with the pulse length on the trigger and
  // reloaded with the hold-off length when the pulse ends.
  // ---------------------------------------------------------------------------
  assign tmr_start = trigger | ((state_reg == ST_ASSERT) & tmr_done);
  assign tmr_load  = (state_reg == ST_IDLE) ? PULSE_LOAD : HOLDOFF_LOAD;

  wdog_rst_timer #(
    .W (TMR_W)
  ) u_timer (
    .wdg_clk (wdg_clk),
    .wdg_rst (wdg_rst),
    .load    (tmr_load),
    .start   (tmr_start),
    .done    (tmr_done)
  );

  // ---------------------------------------------------------------------------
  // Controller FSM with registered sys_rst_req and busy.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wdg_clk) begin
    if (wdg_rst) begin
      state_reg   <= ST_IDLE;
      sys_rst_req <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (trigger) begin
            state_reg   <= ST_ASSERT;
            sys_rst_req <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (tmr_done) begin
            state_reg   <= ST_HOLDOFF;
            sys_rst_req <= 1'b0;
          end
        end
        ST_HOLDOFF: begin
          if (tmr_done) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          sys_rst_req <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wdog_rst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wdog_rst_ctrl
// Two controllers share one stimulus stream: dut_a with default parameters and
// dut_b with a short pulse/hold-off, ESC_CYCLES=8 and CNT_W=2. A reference
// model tracks each controller as "edge of the last accepted trigger" plus
// sticky cause/count values; pulse and busy windows follow from arithmetic on
// that edge number. Directed steps exercise the documented scenarios, then a
// randomized phase runs against the same model.
// -----------------------------------------------------------------------------
module tb_wdog_rst_ctrl;

  localparam int PA = 16, HA = 64, EA = 1024, CA = 8;
  localparam int PB = 3,  HB = 4,  EB = 8,    CB = 2;
  localparam int NEVER = -1000000;

`ifdef WDOG_RST_CTRL_ESCALATE_EN
  localparam bit ESC_EN = 1'b1;
`else
  localparam bit ESC_EN = 1'b0;
`endif

  logic wdg_clk = 1'b0;
  always #5 wdg_clk = ~wdg_clk;

  logic wdg_rst, wdogint, wdogres, irq_clr, cause_clr;

  logic          a_sys_rst_req, a_wdog_irq, a_busy;
  logic [1:0]    a_rst_cause;
  logic [CA-1:0] a_rst_count;
  logic          b_sys_rst_req, b_wdog_irq, b_busy;
  logic [1:0]    b_rst_cause;
  logic [CB-1:0] b_rst_count;

  wdog_rst_ctrl #(
    .RST_PULSE (PA), .HOLDOFF (HA), .ESC_CYCLES (EA), .CNT_W (CA)
  ) dut_a (
    .wdg_clk     (wdg_clk),
    .wdg_rst     (wdg_rst),
    .wdogint     (wdogint),
    .wdogres     (wdogres),
    .irq_clr     (irq_clr),
    .cause_clr   (cause_clr),
    .sys_rst_req (a_sys_rst_req),
    .wdog_irq    (a_wdog_irq),
    .rst_cause   (a_rst_cause),
    .rst_count   (a_rst_count),
    .busy        (a_busy)
  );

  wdog_rst_ctrl #(
    .RST_PULSE (PB), .HOLDOFF (HB), .ESC_CYCLES (EB), .CNT_W (CB)
  ) dut_b (
    .wdg_clk     (wdg_clk),
    .wdg_rst     (wdg_rst),
    .wdogint     (wdogint),
    .wdogres     (wdogres),
    .irq_clr     (irq_clr),
    .cause_clr   (cause_clr),
    .sys_rst_req (b_sys_rst_req),
    .wdog_irq    (b_wdog_irq),
    .rst_cause   (b_rst_cause),
    .rst_count   (b_rst_count),
    .busy        (b_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state.
  int m_p[2], m_h[2], m_e[2], m_cmax[2];
  int m_trig[2], m_cause[2], m_count[2];
  bit m_armed, m_prev_res, m_prev_int, m_irq;
  int m_irq_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Evaluate one clock edge of the model with the inputs as sampled there.
  task automatic model_edge();
    bit res_rise, int_rise, busy_prev, esc_hit, go;
    int esc_start;
    cyc++;
    if (wdg_rst) begin
      m_armed = 0; m_prev_res = 0; m_prev_int = 0; m_irq = 0;
      for (int d = 0; d < 2; d++) begin
        m_trig[d] = NEVER; m_cause[d] = 0; m_count[d] = 0;
      end
      return;
    end
    // A level already high across reset is not a rise.
    res_rise = m_armed && wdogres && !m_prev_res;
    int_rise = m_armed && wdogint && !m_prev_int;
    for (int d = 0; d < 2; d++) begin
      // Busy for P+H edges starting at the trigger edge.
      busy_prev = (cyc - 1 - m_trig[d]) < (m_p[d] + m_h[d]);
      // Escalation: interrupt pending for E cycles since it rose or since the
      // last reset pulse began, whichever is later.
      esc_start = (m_irq_edge > m_trig[d]) ? m_irq_edge : m_trig[d];
      esc_hit   = ESC_EN && m_irq && ((cyc - esc_start) >= m_e[d]);
      go        = !busy_prev && (res_rise || esc_hit);
      if (cause_clr) begin
        m_cause[d] = 0; m_count[d] = 0;
      end
      if (go) begin
        if (res_rise) m_cause[d] |= 1;
        if (esc_hit)  m_cause[d] |= 2;
        if (m_count[d] < m_cmax[d]) m_count[d]++;
        m_trig[d] = cyc;
      end
    end
    if (int_rise) begin
      if (!m_irq) m_irq_edge = cyc;
      m_irq = 1;
    end else if (irq_clr) begin
      m_irq = 0;
    end
    m_prev_res = wdogres; m_prev_int = wdogint; m_armed = 1;
  endtask

  function automatic bit exp_req(int d);
    return (cyc - m_trig[d]) < m_p[d];
  endfunction

  function automatic bit exp_busy(int d);
    return (cyc - m_trig[d]) < (m_p[d] + m_h[d]);
  endfunction

  task automatic check_model();
    chk("a_sys_rst_req", a_sys_rst_req, exp_req(0));
    chk("a_busy",        a_busy,        exp_busy(0));
    chk("a_wdog_irq",    a_wdog_irq,    m_irq);
    chk("a_rst_cause",   a_rst_cause,   m_cause[0]);
    chk("a_rst_count",   a_rst_count,   m_count[0]);
    chk("b_sys_rst_req", b_sys_rst_req, exp_req(1));
    chk("b_busy",        b_busy,        exp_busy(1));
    chk("b_wdog_irq",    b_wdog_irq,    m_irq);
    chk("b_rst_cause",   b_rst_cause,   m_cause[1]);
    chk("b_rst_count",   b_rst_count,   m_count[1]);
  endtask

  // One clock: model evaluates at the edge, outputs are checked 1 ns later.
  task automatic step();
    @(posedge wdg_clk);
    model_edge();
    #1;
    check_model();
    $display("cyc %0d rst=%0b res=%0b int=%0b clr=%0b cclr=%0b | A req=%0b busy=%0b irq=%0b cause=%0d cnt=%0d | B req=%0b busy=%0b cause=%0d cnt=%0d",
             cyc, wdg_rst, wdogres, wdogint, irq_clr, cause_clr,
             a_sys_rst_req, a_busy, a_wdog_irq, a_rst_cause, a_rst_count,
             b_sys_rst_req, b_busy, b_rst_cause, b_rst_count);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    m_p    = '{PA, PB};
    m_h    = '{HA, HB};
    m_e    = '{EA, EB};
    m_cmax = '{(1 << CA) - 1, (1 << CB) - 1};
    m_trig = '{NEVER, NEVER};
    m_cause = '{0, 0};
    m_count = '{0, 0};
    m_armed = 0; m_prev_res = 0; m_prev_int = 0; m_irq = 0; m_irq_edge = NEVER;

    wdg_rst = 1'b1; wdogint = 1'b0; wdogres = 1'b0; irq_clr = 1'b0; cause_clr = 1'b0;

    // Reset state.
    steps(3);
    chk("reset_req",   a_sys_rst_req, 0);
    chk("reset_busy",  a_busy,        0);
    chk("reset_irq",   a_wdog_irq,    0);
    chk("reset_cause", a_rst_cause,   0);
    chk("reset_count", a_rst_count,   0);
    wdg_rst = 1'b0;
    steps(5);

    // wdogres rise: 16-cycle pulse, busy for 80 cycles, second rise inside
    // the hold-off window at relative edge 30 is ignored.
    for (int i = 0; i < 100; i++) begin
      wdogres = (i < 5) || (i >= 30 && i < 35);
      step();
      chk("pulse_window", a_sys_rst_req, (i < 16));
      chk("busy_window",  a_busy,        (i < 80));
    end
    wdogres = 1'b0;
    chk("pulse_cause", a_rst_cause, 1);
    chk("pulse_count", a_rst_count, 1);

    // Interrupt: set wins over a coincident acknowledge; later ack clears.
    wdogint = 1'b1; irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_set_wins", a_wdog_irq, 1);
    steps(4);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_ack", a_wdog_irq, 0);
    wdogint = 1'b0;
    step();

    // Escalation on dut_b (ESC_CYCLES=8); without the feature nothing fires
    // and cause bit1 stays 0.
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
    wdogint = 1'b1;
    step();
    chk("esc_irq_set", b_wdog_irq, 1);
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("esc_pulse", b_sys_rst_req, ESC_EN && (j >= 8) && (j < 8 + PB));
    end
    chk("esc_cause", b_rst_cause, ESC_EN ? 2 : 0);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0; wdogint = 1'b0;
    steps(20);

    // Coincident trigger and cause_clr: clear first, then cause=01, count=1.
    wdogres = 1'b1; step(); wdogres = 1'b0;
    steps(10);
    wdogres = 1'b1; cause_clr = 1'b1;
    step();
    wdogres = 1'b0; cause_clr = 1'b0;
    chk("clr_vs_trig_cause", b_rst_cause, 1);
    chk("clr_vs_trig_count", b_rst_count, 1);
    // Four more triggers on the 2-bit counter saturate it at 3.
    for (int t = 0; t < 4; t++) begin
      steps(10);
      wdogres = 1'b1; step(); wdogres = 1'b0;
    end
    steps(10);
    chk("count_saturate", b_rst_count, 3);
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
    chk("cause_clr_cause", b_rst_cause, 0);
    chk("cause_clr_count", b_rst_count, 0);

    // Power-on reset in the 5th cycle of ASSERT, wdogres held high.
    steps(100);
    wdogres = 1'b1;
    steps(5);
    chk("pre_rst_req", a_sys_rst_req, 1);
    wdg_rst = 1'b1;
    step();
    wdg_rst = 1'b0;
    chk("midrst_req",   a_sys_rst_req, 0);
    chk("midrst_busy",  a_busy,        0);
    chk("midrst_irq",   a_wdog_irq,    0);
    chk("midrst_cause", a_rst_cause,   0);
    chk("midrst_count", a_rst_count,   0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("held_no_retrig_req",  a_sys_rst_req, 0);
      chk("held_no_retrig_busy", a_busy,        0);
    end
    wdogres = 1'b0;
    step();

    // Randomized phase against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) wdogres = ~wdogres;
      if ($urandom_range(29) == 0) wdogint = ~wdogint;
      irq_clr   = ($urandom_range(24) == 0);
      cause_clr = ($urandom_range(59) == 0);
      wdg_rst   = ($urandom_range(399) == 0);
      step();
    end
    wdg_rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wdog_rst_ctrl.md
WDOG_RST_CTRL -- requirements
Module: wdog_rst_ctrl

Interface
REQ-001 SHALL have parameter RST_PULSE, default 16: sys_rst_req high time in cycles, legal range 1..255.
REQ-002 SHALL have parameter HOLDOFF, default 64: cycles after the pulse during which wdogres is ignored, legal range 1..255.
REQ-003 SHALL have parameter ESC_CYCLES, default 1024: unacknowledged-interrupt escalation limit, legal range 1..65535.
REQ-004 SHALL have parameter CNT_W, default 8: width of rst_count.
REQ-005 SHALL have port wdg_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port wdg_rst, input, 1 bit: synchronous active-high power-on reset, never driven by sys_rst_req.
REQ-007 SHALL have port wdogint, input, 1 bit: level interrupt from the watchdog, synchronous to wdg_clk.
REQ-008 SHALL have port wdogres, input, 1 bit: level reset request from the watchdog, synchronous to wdg_clk.
REQ-009 SHALL have port irq_clr, input, 1 bit: single-cycle acknowledge of wdog_irq.
REQ-010 SHALL have port cause_clr, input, 1 bit: single-cycle clear of rst_cause and rst_count.
REQ-011 SHALL have port sys_rst_req, output, 1 bit: stretched reset request to the system reset generator.
REQ-012 SHALL have port wdog_irq, output, 1 bit: sticky interrupt.
REQ-013 SHALL have port rst_cause, output, 2 bits: bit0 = wdogres-triggered, bit1 = escalation-triggered; both bits sticky.
REQ-014 SHALL have port rst_count, output, CNT_W bits: count of issued reset pulses.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL detect rising edges of wdogint and wdogres against a registered copy of each signal, reset value 0.
REQ-017 SHALL set wdog_irq on the edge following a detected wdogint rise and hold it until the edge following irq_clr; if set and clear coincide, set SHALL win.
REQ-018 SHALL implement FSM states IDLE, ASSERT and HOLDOFF.
REQ-019 SHALL, on a wdogres rise sampled in IDLE at edge N, move to ASSERT and drive sys_rst_req high from edge N+1 for exactly RST_PULSE cycles.
REQ-020 SHALL, at the end of ASSERT, move to HOLDOFF for exactly HOLDOFF cycles, then return to IDLE.
REQ-021 SHALL ignore wdogres rises occurring in ASSERT or HOLDOFF: no pulse extension and no count increment.
REQ-022 SHALL set the applicable rst_cause bit and increment rst_count on the IDLE-to-ASSERT transition.
REQ-023 SHALL saturate rst_count at 2^CNT_W-1.
REQ-024 SHALL give a coincident trigger priority over cause_clr: the register is cleared, then set bit and count = 1 apply.
REQ-025 SHALL use a wdogres level that stays high after HOLDOFF only when it rises again; a held level SHALL NOT retrigger.
REQ-026 SHALL drive sys_rst_req and busy from registers (no combinational path from inputs).

Reset
REQ-027 SHALL, on wdg_rst high at any edge (including mid-ASSERT), next cycle set state IDLE, sys_rst_req 0, wdog_irq 0, rst_cause 0, rst_count 0, busy 0, all counters 0 and the edge registers 0.

Configuration
REQ-028 SHALL, with WDOG_RST_CTRL_ESCALATE_EN defined, count consecutive cycles with wdog_irq high and, on reaching ESC_CYCLES in IDLE, enter ASSERT with rst_cause bit1 set; the count SHALL clear when wdog_irq falls or on entering ASSERT.
REQ-029 SHALL, without WDOG_RST_CTRL_ESCALATE_EN, omit the escalation counter and tie rst_cause bit1 to 0.
REQ-030 SHALL, when an escalation trigger and a wdogres rise coincide, set both cause bits and increment rst_count once.

Structure
REQ-031 SHALL place the FSM state enum typedef and the cause-bit index constants in shared package wdog_rst_pkg.
REQ-032 SHALL implement the pulse/holdoff timing as one reusable sub-module wdog_rst_timer (load value, start, done).

Verification
REQ-033 SHALL test: wdogres rise at edge 10, defaults -> sys_rst_req high for edges 11..26, busy until edge 90, rst_cause=01, rst_count=1.
REQ-034 SHALL test: second wdogres rise at edge 40 (in HOLDOFF) -> no new pulse, rst_count stays 1.
REQ-035 SHALL test: wdogint rise, with irq_clr at the same edge -> wdog_irq stays 1; irq_clr alone 5 cycles later -> wdog_irq=0.
REQ-036 SHALL test: macro defined, ESC_CYCLES=8, wdogint rise with no irq_clr -> pulse starts 8 cycles after wdog_irq rises, rst_cause=10.
REQ-037 SHALL test: CNT_W=2 with 5 triggers -> rst_count=3; then cause_clr -> rst_cause=0 and rst_count=0.
REQ-038 SHALL test: wdg_rst asserted at the 5th cycle of ASSERT -> all outputs 0 the next cycle; wdogres still high afterwards -> no retrigger.
